// File: rtl/board_pkg.sv
// Shared types, sizes and the cursor-scan helper for the 4x4 pair-matching game.
package board_pkg;

    localparam int N_CARDS = 16;
    localparam int N_PAIRS = 8;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        PICK1,
        PICK2,
        COMPARE,
        SHOW,
        DONE
    } state_t;

    // First index after cursor (wrapping) whose mask bit is set; cursor if none.
    function automatic logic [IDX_W-1:0] next_selectable(
        input logic [IDX_W-1:0]   cursor,
        input logic [N_CARDS-1:0] mask
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] res;
        logic             found;
        res   = cursor;
        found = 1'b0;
        for (int k = 1; k < N_CARDS; k++) begin
            idx = cursor + IDX_W'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/board_ctrl_timer.sv
// Reveal timer: loads a count and decrements while enabled; done is high at zero.
module reveal_timer #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/board_ctrl.sv
// Pair-matching game sequencer: owns cursor, face-up/matched masks, reveal timer and score.
module board_ctrl
    import board_pkg::*;
#(
    parameter int VAL_W       = 3,
    parameter int SHOW_CYCLES = 25000000,
    parameter int ATT_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btn_next,
    input  logic                       btn_sel,
    input  logic                       btn_restart,
    input  logic [N_CARDS*VAL_W-1:0]   card_val,
    output logic [IDX_W-1:0]           cursor,
    output logic [N_CARDS-1:0]         revealed,
    output logic [N_CARDS-1:0]         matched,
    output logic [ATT_W-1:0]           attempts,
    output logic [3:0]                 pairs,
    output logic                       busy,
    output logic                       game_over
);

    localparam int TMR_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     cursor_q, cursor_d;
    logic [IDX_W-1:0]     first_q, first_d;
    logic [IDX_W-1:0]     second_q, second_d;
    logic [N_CARDS-1:0]   revealed_q, revealed_d;
    logic [N_CARDS-1:0]   matched_q, matched_d;
    logic [ATT_W-1:0]     attempts_q, attempts_d;
    logic [3:0]           pairs_q, pairs_d;
    logic                 busy_q, busy_d;
    logic                 game_over_q, game_over_d;

    logic [N_CARDS-1:0]   selectable;
    logic [N_CARDS-1:0]   pair_mask;
    logic [VAL_W-1:0]     val_first;
    logic [VAL_W-1:0]     val_second;
    logic [3:0]           pairs_inc;
    logic                 tmr_load;
    logic                 tmr_done;

    assign selectable = ~(matched_q | revealed_q);
    assign pair_mask  = (N_CARDS'(1) << first_q) | (N_CARDS'(1) << second_q);
    assign val_first  = card_val[first_q*VAL_W +: VAL_W];
    assign val_second = card_val[second_q*VAL_W +: VAL_W];
    assign pairs_inc  = pairs_q + 4'd1;

    reveal_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (btn_restart),
        .load_i     (tmr_load),
        .load_val_i (TMR_W'(SHOW_CYCLES - 1)),
        .dec_i      (state_q == SHOW),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        first_d     = first_q;
        second_d    = second_q;
        revealed_d  = revealed_q;
        matched_d   = matched_q;
        attempts_d  = attempts_q;
        pairs_d     = pairs_q;
        tmr_load    = 1'b0;

        if (btn_restart) begin
            state_d    = PICK1;
            cursor_d   = '0;
            first_d    = '0;
            second_d   = '0;
            revealed_d = '0;
            matched_d  = '0;
            attempts_d = '0;
            pairs_d    = '0;
        end else begin
            case (state_q)
                PICK1: begin
                    if (btn_sel) begin
                        if (selectable[cursor_q]) begin
                            revealed_d[cursor_q] = 1'b1;
                            first_d              = cursor_q;
                            state_d              = PICK2;
                        end
                    end else if (btn_next) begin
                        cursor_d = next_selectable(cursor_q, selectable);
                    end
                end
                PICK2: begin
                    // The first card is already revealed, so re-selecting it falls through here.
                    if (btn_sel) begin
                        if (selectable[cursor_q]) begin
                            revealed_d[cursor_q] = 1'b1;
                            second_d             = cursor_q;
                            state_d              = COMPARE;
                        end
                    end else if (btn_next) begin
                        cursor_d = next_selectable(cursor_q, selectable);
                    end
                end
                COMPARE: begin
                    if (attempts_q != '1) begin
                        attempts_d = attempts_q + ATT_W'(1);
                    end
                    if (val_first == val_second) begin
                        matched_d  = matched_q | pair_mask;
                        revealed_d = revealed_q & ~pair_mask;
                        pairs_d    = pairs_inc;
                        state_d    = (pairs_inc == 4'(N_PAIRS)) ? DONE : PICK1;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = SHOW;
                    end
                end
                SHOW: begin
                    if (tmr_done) begin
                        revealed_d = revealed_q & ~pair_mask;
                        state_d    = PICK1;
                    end
                end
                DONE: begin
                end
                default: state_d = PICK1;
            endcase
        end

        busy_d      = (state_d == COMPARE) || (state_d == SHOW);
        game_over_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PICK1;
            cursor_q    <= '0;
            first_q     <= '0;
            second_q    <= '0;
            revealed_q  <= '0;
            matched_q   <= '0;
            attempts_q  <= '0;
            pairs_q     <= '0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            first_q     <= first_d;
            second_q    <= second_d;
            revealed_q  <= revealed_d;
            matched_q   <= matched_d;
            attempts_q  <= attempts_d;
            pairs_q     <= pairs_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign cursor    = cursor_q;
    assign revealed  = revealed_q;
    assign matched   = matched_q;
    assign attempts  = attempts_q;
    assign pairs     = pairs_q;
    assign busy      = busy_q;
    assign game_over = game_over_q;

endmodule
